sump_cmd_dec: RTL and testbench

Command decoder for the SUMP logic-analyzer protocol, on the host-to-device path. It takes bytes from the UART receiver and assembles short (1-byte) and long (5-byte) commands. It then emits single-cycle strobes that drive the capture controller: run, set-count, and generic long-command execute with 32-bit argument. It is the receive-side counterpart of the controller/transmitter path that returns samples to the host.

---
 rtl/sump_cmd_dec_if.sv | 27 ++
 rtl/sump_cmd_dec.sv | 130 +++++++++++++
 tb/tb_sump_cmd_dec.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sump_cmd_dec_if.sv
// Host-to-device command link: received UART bytes in, decoded SUMP strobes and
// the held opcode/argument out.
interface sump_cmd_dec_if #(
    parameter int CMD_WIDTH = 32
);
    logic                 rx_stb_i;
    logic [7:0]           rx_data_i;
    logic                 run_o;
    logic                 id_o;
    logic                 meta_o;
    logic                 soft_rst_o;
    logic                 set_cnt_o;
    logic                 exec_o;
    logic [7:0]           opc_o;
    logic [CMD_WIDTH-1:0] cmd_o;
    logic                 busy_o;

    modport master (
        output rx_stb_i, rx_data_i,
        input  run_o, id_o, meta_o, soft_rst_o, set_cnt_o, exec_o, opc_o, cmd_o, busy_o
    );

    modport slave (
        input  rx_stb_i, rx_data_i,
        output run_o, id_o, meta_o, soft_rst_o, set_cnt_o, exec_o, opc_o, cmd_o, busy_o
    );
endinterface

// File: rtl/sump_cmd_dec.sv
// SUMP command decoder: assembles 1-byte and 5-byte host commands from the UART
// byte stream and emits single-cycle registered strobes to the capture controller.
module sump_cmd_dec #(
    parameter int CMD_WIDTH = 32,
    parameter int TIMEOUT   = 65535
) (
    input  logic            clk_i,
    input  logic            rst_i,
    sump_cmd_dec_if.slave   bus
);
    // The argument is exactly four LSB-first byte lanes; lanes 0..2 are buffered,
    // lane 3 is taken straight from the completing byte.
    localparam int ARG_W = CMD_WIDTH - 8;
    localparam int TW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT);

    typedef enum logic {S_IDLE, S_ARG} state_t;

    state_t               r_state,    w_next_state;
    logic [1:0]           r_byte_cnt, w_byte_cnt;
    logic [TW-1:0]        r_tmo_cnt,  w_tmo_cnt;
    logic [7:0]           r_shadow,   w_shadow;
    logic [ARG_W-1:0]     r_arg,      w_arg;
    logic [7:0]           r_opc,      w_opc;
    logic [CMD_WIDTH-1:0] r_cmd,      w_cmd;
    logic                 r_run, r_id, r_meta, r_soft_rst, r_set_cnt, r_exec, r_busy;
    logic                 w_run, w_id, w_meta, w_soft_rst, w_set_cnt, w_exec;
    logic                 w_timeout;
    state_t               w_cur_state;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves
        // a signal unassigned and no latch is inferred.
        w_next_state = r_state;
        w_byte_cnt   = r_byte_cnt;
        w_tmo_cnt    = r_tmo_cnt;
        w_shadow     = r_shadow;
        w_arg        = r_arg;
        w_opc        = r_opc;
        w_cmd        = r_cmd;
        w_run        = 1'b0;
        w_id         = 1'b0;
        w_meta       = 1'b0;
        w_soft_rst   = 1'b0;
        w_set_cnt    = 1'b0;
        w_exec       = 1'b0;

        // Timeout is resolved before the byte, so a coincident byte starts a new command.
        w_timeout   = (TIMEOUT != 0) && (r_state == S_ARG) && (r_tmo_cnt == TMO_LIMIT);
        w_cur_state = w_timeout ? S_IDLE : r_state;
        w_next_state = w_cur_state;

        if (bus.rx_stb_i) begin
            w_tmo_cnt = '0;
            if (w_cur_state == S_IDLE) begin
                if (bus.rx_data_i[7]) begin
                    w_shadow     = bus.rx_data_i;
                    w_byte_cnt   = 2'd0;
                    w_next_state = S_ARG;
                end else begin
                    w_opc = bus.rx_data_i;
                    unique case (bus.rx_data_i)
                        8'h00:   w_soft_rst = 1'b1;
                        8'h01:   w_run      = 1'b1;
                        8'h02:   w_id       = 1'b1;
                        8'h04:   w_meta     = 1'b1;
                        default: ;
                    endcase
                end
            end else if (r_byte_cnt == 2'd3) begin
                w_cmd        = {bus.rx_data_i, r_arg};
                w_opc        = r_shadow;
                w_exec       = 1'b1;
                w_set_cnt    = (r_shadow == 8'h81);
                w_next_state = S_IDLE;
            end else begin
                w_arg[{r_byte_cnt, 3'b000} +: 8] = bus.rx_data_i;
                w_byte_cnt = r_byte_cnt + 2'd1;
            end
        end else if (r_state == S_ARG && r_tmo_cnt != TMO_LIMIT) begin
            w_tmo_cnt = r_tmo_cnt + TW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values regardless of statement order.
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_byte_cnt <= '0;
            r_tmo_cnt  <= '0;
            r_shadow   <= '0;
            r_arg      <= '0;
            r_opc      <= '0;
            r_cmd      <= '0;
            r_run      <= 1'b0;
            r_id       <= 1'b0;
            r_meta     <= 1'b0;
            r_soft_rst <= 1'b0;
            r_set_cnt  <= 1'b0;
            r_exec     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_byte_cnt <= w_byte_cnt;
            r_tmo_cnt  <= w_tmo_cnt;
            r_shadow   <= w_shadow;
            r_arg      <= w_arg;
            r_opc      <= w_opc;
            r_cmd      <= w_cmd;
            r_run      <= w_run;
            r_id       <= w_id;
            r_meta     <= w_meta;
            r_soft_rst <= w_soft_rst;
            r_set_cnt  <= w_set_cnt;
            r_exec     <= w_exec;
            r_busy     <= (w_next_state == S_ARG);
        end
    end

    assign bus.run_o      = r_run;
    assign bus.id_o       = r_id;
    assign bus.meta_o     = r_meta;
    assign bus.soft_rst_o = r_soft_rst;
    assign bus.set_cnt_o  = r_set_cnt;
    assign bus.exec_o     = r_exec;
    assign bus.opc_o      = r_opc;
    assign bus.cmd_o      = r_cmd;
    assign bus.busy_o     = r_busy;
endmodule

// File: tb/tb_sump_cmd_dec.sv
// Self-checking bench for sump_cmd_dec: directed scenarios plus randomized byte
// streams, all compared against a byte-queue reference model of the protocol.
module tb_sump_cmd_dec;
    localparam int TMO = 8;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    sump_cmd_dec_if #(.CMD_WIDTH(32)) bus ();

    sump_cmd_dec #(.CMD_WIDTH(32), .TIMEOUT(TMO)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: pending argument bytes kept in a queue, idle gap counted.
    bit         m_in_arg;
    logic [7:0] m_op;
    logic [7:0] m_args[$];
    int         m_idle;
    logic       m_run, m_id, m_meta, m_soft, m_set, m_exec, m_busy;
    logic [7:0] m_opc;
    logic [31:0] m_cmd;

    task automatic model_reset();
        m_in_arg = 0; m_op = 8'h00; m_args.delete(); m_idle = 0;
        {m_run, m_id, m_meta, m_soft, m_set, m_exec, m_busy} = '0;
        m_opc = 8'h00; m_cmd = 32'h0;
    endtask

    task automatic model_step(input logic stb, input logic [7:0] d);
        {m_run, m_id, m_meta, m_soft, m_set, m_exec} = '0;
        if (m_in_arg && m_idle >= TMO) begin
            m_in_arg = 0;
            m_args.delete();
        end
        if (stb) begin
            if (m_in_arg) begin
                m_args.push_back(d);
                m_idle = 0;
                if (m_args.size() == 4) begin
                    m_cmd    = {m_args[3], m_args[2], m_args[1], m_args[0]};
                    m_opc    = m_op;
                    m_exec   = 1;
                    m_set    = (m_op == 8'h81);
                    m_in_arg = 0;
                    m_args.delete();
                end
            end else if (d >= 8'h80) begin
                m_in_arg = 1; m_op = d; m_idle = 0; m_args.delete();
            end else begin
                m_opc  = d;
                m_soft = (d == 8'h00);
                m_run  = (d == 8'h01);
                m_id   = (d == 8'h02);
                m_meta = (d == 8'h04);
            end
        end else if (m_in_arg) begin
            m_idle++;
        end
        m_busy = m_in_arg;
    endtask

    function automatic logic [46:0] obs_vec();
        return {bus.run_o, bus.id_o, bus.meta_o, bus.soft_rst_o, bus.set_cnt_o,
                bus.exec_o, bus.busy_o, bus.opc_o, bus.cmd_o};
    endfunction

    function automatic logic [46:0] exp_vec();
        return {m_run, m_id, m_meta, m_soft, m_set, m_exec, m_busy, m_opc, m_cmd};
    endfunction

    // One clock: present inputs, clock the DUT and the model, sample 1 ns later.
    task automatic drive(input logic stb, input logic [7:0] d);
        bus.rx_stb_i  = stb;
        bus.rx_data_i = d;
        @(posedge clk_i);
        model_step(stb, d);
        #1;
        bus.rx_stb_i = 1'b0;
    endtask

    task automatic test_reset();
        bus.rx_stb_i = 1'b0; bus.rx_data_i = 8'h00;
        model_reset();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #3 rst_i = 1'b0;
        @(posedge clk_i); #1;
        checks++;
        if (obs_vec() !== 47'h0) begin
            failures++;
            $display("FAIL reset_state: got %h expected %h", obs_vec(), 47'h0);
        end
    endtask

    task automatic test_short_run();
        drive(1, 8'h01);
        checks++;
        if (obs_vec() !== exp_vec() || bus.run_o !== 1'b1 || bus.opc_o !== 8'h01) begin
            failures++;
            $display("FAIL run_strobe: got %h expected %h", obs_vec(), exp_vec());
        end
        drive(0, 8'h00);
        checks++;
        if (bus.run_o !== 1'b0 || obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL run_one_cycle: got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_set_cnt();
        logic [7:0] seq [5] = '{8'h81, 8'h10, 8'h00, 8'h20, 8'h00};
        for (int i = 0; i < 5; i++) begin
            drive(1, seq[i]);
            checks++;
            if (obs_vec() !== exp_vec() || bus.busy_o !== (i < 4)) begin
                failures++;
                $display("FAIL set_cnt_byte%0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (bus.cmd_o !== 32'h0020_0010 || bus.set_cnt_o !== 1'b1 || bus.exec_o !== 1'b1
            || bus.opc_o !== 8'h81) begin
            failures++;
            $display("FAIL set_cnt_word: got cmd %h set %b exec %b expected cmd 00200010 set 1 exec 1",
                     bus.cmd_o, bus.set_cnt_o, bus.exec_o);
        end
        drive(0, 8'h00);
        checks++;
        if (bus.exec_o !== 1'b0 || bus.set_cnt_o !== 1'b0) begin
            failures++;
            $display("FAIL set_cnt_one_cycle: got exec %b set %b expected 0 0", bus.exec_o, bus.set_cnt_o);
        end
    endtask

    task automatic test_bit7_arg();
        logic [7:0] seq [5] = '{8'hC0, 8'h01, 8'h81, 8'h00, 8'h02};
        for (int i = 0; i < 5; i++) begin
            drive(1, seq[i]);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL bit7_arg_byte%0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (bus.opc_o !== 8'hC0 || bus.cmd_o !== 32'h0200_8101 || bus.set_cnt_o !== 1'b0
            || bus.exec_o !== 1'b1 || bus.run_o !== 1'b0) begin
            failures++;
            $display("FAIL bit7_arg_word: got opc %h cmd %h set %b expected opc c0 cmd 02008101 set 0",
                     bus.opc_o, bus.cmd_o, bus.set_cnt_o);
        end
    endtask

    task automatic test_timeout();
        logic [31:0] prior_cmd;
        prior_cmd = m_cmd;
        drive(1, 8'h81);
        drive(1, 8'hAA);
        for (int i = 0; i < TMO; i++) begin
            drive(0, 8'h00);
            checks++;
            if (obs_vec() !== exp_vec() || bus.busy_o !== 1'b1) begin
                failures++;
                $display("FAIL timeout_wait%0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        drive(1, 8'h01);
        checks++;
        if (obs_vec() !== exp_vec() || bus.run_o !== 1'b1 || bus.exec_o !== 1'b0
            || bus.busy_o !== 1'b0 || bus.cmd_o !== prior_cmd) begin
            failures++;
            $display("FAIL timeout_abort: got %h expected %h", obs_vec(), exp_vec());
        end
        // One cycle short of the limit: the byte still belongs to the argument.
        drive(1, 8'h81);
        drive(1, 8'h11);
        for (int i = 0; i < TMO - 1; i++) drive(0, 8'h00);
        drive(1, 8'h22);
        drive(1, 8'h33);
        drive(1, 8'h44);
        checks++;
        if (obs_vec() !== exp_vec() || bus.exec_o !== 1'b1 || bus.cmd_o !== 32'h4433_2211) begin
            failures++;
            $display("FAIL timeout_edge: got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_reset_mid_arg();
        drive(1, 8'h81);
        drive(1, 8'h11);
        drive(1, 8'h22);
        #2 rst_i = 1'b1;
        model_reset();
        #1;
        checks++;
        if (obs_vec() !== 47'h0) begin
            failures++;
            $display("FAIL reset_mid_arg: got %h expected %h", obs_vec(), 47'h0);
        end
        @(posedge clk_i);
        #3 rst_i = 1'b0;
        drive(1, 8'h02);
        checks++;
        if (obs_vec() !== exp_vec() || bus.id_o !== 1'b1 || bus.exec_o !== 1'b0) begin
            failures++;
            $display("FAIL id_after_reset: got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [7] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h11, 8'h04};
        int soft_pulses = 0;
        for (int i = 0; i < 7; i++) begin
            drive(1, seq[i]);
            soft_pulses += int'(bus.soft_rst_o);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL b2b_byte%0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (soft_pulses != 5 || bus.meta_o !== 1'b1 || bus.opc_o !== 8'h04) begin
            failures++;
            $display("FAIL b2b_summary: got pulses %0d meta %b opc %h expected 5 1 04",
                     soft_pulses, bus.meta_o, bus.opc_o);
        end
    endtask

    task automatic test_random();
        logic [7:0] pool [8] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h11, 8'h81, 8'hC0, 8'h13};
        int bad = 0;
        for (int n = 0; n < 600; n++) begin
            int gap;
            logic [7:0] d;
            gap = ($urandom_range(0, 9) == 0) ? $urandom_range(TMO - 2, TMO + 2) : $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                drive(0, 8'($urandom));
                checks++;
                if (obs_vec() !== exp_vec()) begin
                    failures++; bad++;
                    if (bad < 10) $display("FAIL random_idle: got %h expected %h", obs_vec(), exp_vec());
                end
            end
            d = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 7)] : 8'($urandom);
            drive(1, d);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++; bad++;
                if (bad < 10) $display("FAIL random_byte %h: got %h expected %h", d, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_short_run();
        test_set_cnt();
        test_bit7_arg();
        test_timeout();
        test_reset_mid_arg();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
